// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited in-order requests to instruction
// memory, buffers {pc, instr} in a small FIFO and drops responses made stale by a redirect.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] pc_out,
   output logic [31:0] instr_out,
   output logic        instr_valid
);

   localparam int unsigned PW        = $clog2(FIFO_DEPTH);
   localparam int unsigned CW        = PW + 1;
   localparam logic [CW:0] DEPTH_LIM = FIFO_DEPTH[CW:0];
   localparam logic [31:0] NOP       = 32'h0000_0013;

   logic [31:0]   fetch_pc;
   logic [31:0]   rsp_pc;
   logic [31:0]   pc_mem  [FIFO_DEPTH];
   logic [31:0]   ins_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop_cnt;
   logic          run;

   logic          empty;
   logic          pop;
   logic          accept;
   logic          rsp_drop;
   logic          push;
   logic [CW:0]   credit_used;
   logic [CW-1:0] outstanding_nxt;
   logic [31:0]   target_pc;

   always_comb begin
      empty           = (count == '0);
      pop             = !empty && !stall;
      // A slot freed by this cycle's pop can already back a new request
      credit_used     = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop};
      imem_req_valid  = run && (credit_used < DEPTH_LIM);
      imem_req_addr   = fetch_pc;
      accept          = imem_req_valid && imem_req_ready;
      rsp_drop        = imem_rsp_valid && (drop_cnt != '0);
      push            = imem_rsp_valid && (drop_cnt == '0) && !redirect;
      outstanding_nxt = outstanding + {{PW{1'b0}}, accept} - {{PW{1'b0}}, imem_rsp_valid};
      target_pc       = {redirect_pc[31:2], 2'b00};
      instr_valid     = !empty;
      pc_out          = empty ? '0  : pc_mem[rd_ptr];
      instr_out       = empty ? NOP : ins_mem[rd_ptr];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run         <= 1'b0;
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         run         <= 1'b1;
         outstanding <= outstanding_nxt;
         if (redirect) begin
            // Everything still in flight after this edge belongs to the old path
            fetch_pc <= target_pc;
            rsp_pc   <= target_pc;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= outstanding_nxt;
         end else begin
            if (accept)
               fetch_pc <= fetch_pc + 32'd4;
            if (push) begin
               rsp_pc <= rsp_pc + 32'd4;
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop)
               rd_ptr <= rd_ptr + PW'(1);
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            if (rsp_drop)
               drop_cnt <= drop_cnt - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]  <= rsp_pc;
         ins_mem[wr_ptr] <= imem_rsp_data;
      end
   end

   a_rsp_outstanding: assert property (@(posedge clk) disable iff (!reset_n)
      imem_rsp_valid |-> (outstanding != '0))
      else $error("imem response with nothing outstanding");

   a_push_full: assert property (@(posedge clk) disable iff (!reset_n)
      (push && !pop) |-> (count != DEPTH_LIM[CW-1:0]))
      else $error("fetch buffer push while full");

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: in-order memory model with programmable latency,
// hand-computed expectations for streaming, stall, backpressure, redirect and reset.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] pc_out;
   logic [31:0] instr_out;
   logic        instr_valid;

   always #5 clk = ~clk;

   if_fetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .stall          (stall),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .pc_out         (pc_out),
      .instr_out      (instr_out),
      .instr_valid    (instr_valid)
   );

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } req_t;

   req_t        pend[$];
   int unsigned checks  = 0;
   int unsigned errors  = 0;
   int unsigned cur_cyc = 0;
   int unsigned lat     = 1;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cur_cyc);
      end
   endtask

   task automatic drive_mem();
      if (pend.size() > 0 && pend[0].due <= cur_cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = word_at(pend[0].addr);
         void'(pend.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end
   endtask

   // Record an accept just before the edge, then step to 1 time unit past it
   task automatic next_cycle();
      req_t r;
      @(negedge clk);
      if (reset_n && imem_req_valid && imem_req_ready) begin
         r.addr = imem_req_addr;
         r.due  = cur_cyc + lat;
         pend.push_back(r);
      end
      @(posedge clk);
      #1;
      cur_cyc++;
      drive_mem();
   endtask

   task automatic do_reset();
      reset_n        = 1'b0;
      stall          = 1'b0;
      redirect       = 1'b0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      pend.delete();
      #1;
      check("rst req_valid",   imem_req_valid, 32'h0);
      check("rst instr_out",   instr_out,      32'h13);
      check("rst instr_valid", instr_valid,    32'h0);
      check("rst pc_out",      pc_out,         32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      cur_cyc = 0;
      #1;
      check("cycle0 req_valid", imem_req_valid, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset_n        = 1'b0;
      stall          = 1'b0;
      redirect       = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      do_reset();

      // Streaming at 1-cycle latency, then a 4-cycle stall
      for (int k = 1; k <= 14; k++) begin
         next_cycle();
         stall = (k >= 7 && k <= 10);
         #1;
         if (k <= 4) begin
            check("stream req_valid", imem_req_valid, 32'h1);
            check("stream req_addr",  imem_req_addr,  32'(4 * (k - 1)));
         end
         if (k >= 3 && k <= 6) begin
            check("stream instr_valid", instr_valid, 32'h1);
            check("stream pc_out",      pc_out,      32'(4 * (k - 3)));
            check("stream instr_out",   instr_out,   word_at(32'(4 * (k - 3))));
         end
         if (k >= 7 && k <= 10) begin
            check("stall req_valid", imem_req_valid, 32'h0);
            check("stall pc_out",    pc_out,         32'h10);
         end
         if (k == 11) begin
            check("resume req_valid", imem_req_valid, 32'h1);
            check("resume req_addr",  imem_req_addr,  32'h18);
         end
         if (k >= 11) begin
            check("resume pc_out",    pc_out,    32'(32'h10 + 4 * (k - 11)));
            check("resume instr_out", instr_out, word_at(32'(32'h10 + 4 * (k - 11))));
         end
      end

      // Mid-stream reset
      do_reset();
      next_cycle();
      #1;
      check("post-rst req_valid", imem_req_valid, 32'h1);
      check("post-rst req_addr",  imem_req_addr,  32'h0);

      // Memory backpressure
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         next_cycle();
         imem_req_ready = !(k >= 5 && k <= 7);
         #1;
         if (k >= 5 && k <= 8) begin
            check("bp req_valid", imem_req_valid, 32'h1);
            check("bp req_addr",  imem_req_addr,  32'h10);
         end
         if (k == 6) check("bp pc_out", pc_out, 32'hC);
         if (k == 7) begin
            check("bp drain instr_out", instr_out, 32'h13);
            check("bp drain pc_out",    pc_out,    32'h0);
         end
         if (k >= 7 && k <= 9) check("bp instr_valid low", instr_valid, 32'h0);
         if (k == 9) check("bp next addr", imem_req_addr, 32'h14);
         if (k == 10) begin
            check("bp resume pc_out",    pc_out,    32'h10);
            check("bp resume instr_out", instr_out, word_at(32'h10));
         end
      end

      // Redirect with two requests in flight, 3-cycle latency
      do_reset();
      lat = 3;
      for (int k = 1; k <= 17; k++) begin
         next_cycle();
         redirect    = (k == 3 || k == 10);
         redirect_pc = (k == 10) ? 32'h103 : 32'h100;
         #1;
         if (k == 1) check("rd req_addr 0", imem_req_addr, 32'h0);
         if (k == 2) check("rd req_addr 4", imem_req_addr, 32'h4);
         if (k == 3) check("rd credit full", imem_req_valid, 32'h0);
         if (k == 4) check("rd nop out", instr_out, 32'h13);
         if (k >= 4 && k <= 8) check("rd stale hidden", instr_valid, 32'h0);
         if (k == 5) begin
            check("rd new req_valid", imem_req_valid, 32'h1);
            check("rd new req_addr",  imem_req_addr,  32'h100);
         end
         if (k == 6) check("rd req_addr 104", imem_req_addr, 32'h104);
         if (k == 9) begin
            check("rd target valid", instr_valid, 32'h1);
            check("rd target pc",    pc_out,      32'h100);
            check("rd target instr", instr_out,   word_at(32'h100));
         end
         if (k == 10) check("rd second pc", pc_out, 32'h104);
         if (k == 11 || k == 16) check("rd2 flushed", instr_valid, 32'h0);
         if (k == 12) check("rd2 credit full", imem_req_valid, 32'h0);
         if (k == 13) begin
            check("rd2 req_valid",       imem_req_valid, 32'h1);
            check("rd2 aligned req_addr", imem_req_addr, 32'h100);
         end
         if (k == 17) begin
            check("rd2 target valid", instr_valid, 32'h1);
            check("rd2 target pc",    pc_out,      32'h100);
         end
      end
      redirect = 1'b0;

      // Redirect while stalled with a same-cycle response
      do_reset();
      lat = 1;
      for (int k = 1; k <= 7; k++) begin
         next_cycle();
         stall       = (k == 4);
         redirect    = (k == 4);
         redirect_pc = 32'h200;
         #1;
         if (k == 4) begin
            check("rs head pc",   pc_out,         32'h4);
            check("rs req_valid", imem_req_valid, 32'h0);
         end
         if (k == 5) begin
            check("rs flushed",   instr_out,      32'h13);
            check("rs req_valid", imem_req_valid, 32'h1);
            check("rs req_addr",  imem_req_addr,  32'h200);
         end
         if (k == 5 || k == 6) check("rs instr_valid low", instr_valid, 32'h0);
         if (k == 6) check("rs req_addr 204", imem_req_addr, 32'h204);
         if (k == 7) begin
            check("rs target valid", instr_valid, 32'h1);
            check("rs target pc",    pc_out,      32'h200);
            check("rs target instr", instr_out,   word_at(32'h200));
         end
      end
      stall    = 1'b0;
      redirect = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
